// File: rtl/udp_reg_responder_pkg.sv
// Shared ring widths, the unmapped-read constant and the word-select type
// for the register-ring responder. No ports; imported by the rtl/ modules.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
`ifndef UDP_REG_DEAD_BEEF
`define UDP_REG_DEAD_BEEF 32'hDEAD_BEEF
`endif

package udp_reg_responder_pkg;
    localparam int ADDR_W = `UDP_REG_ADDR_WIDTH;
    localparam int DATA_W = `CPCI_NF2_DATA_WIDTH;
    localparam logic [31:0] DEAD_BEEF = `UDP_REG_DEAD_BEEF;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_CNTR = 2'd1,
        SEL_SW   = 2'd2
    } sel_e;
endpackage

// File: rtl/udp_reg_cntr_bank.sv
// Bank of NUM_CNTR event counters: +1 strobes, write-load, clear-on-read.
// Ports: clk, reset, inc, idx, wr_en, clr_en, wr_data -> rd_data (zero-extended).
module udp_reg_cntr_bank
    import udp_reg_responder_pkg::*;
#(
    parameter int NUM_CNTR   = 4,
    parameter int CNTR_WIDTH = 32,
    parameter int IDX_W      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CNTR-1:0]   inc,
    input  logic [IDX_W-1:0]      idx,
    input  logic                  wr_en,
    input  logic                  clr_en,
    input  logic [CNTR_WIDTH-1:0] wr_data,
    output logic [DATA_W-1:0]     rd_data
);

    logic [CNTR_WIDTH-1:0] cnt [NUM_CNTR];

    // Priority: write beats everything; a clearing read keeps a
    // same-cycle increment as the new count of 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CNTR; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CNTR; i++) begin
                if (wr_en && idx == IDX_W'(i)) begin
                    cnt[i] <= wr_data;
                end else if (clr_en && idx == IDX_W'(i)) begin
                    cnt[i] <= CNTR_WIDTH'(inc[i]);
                end else if (inc[i]) begin
                    cnt[i] <= cnt[i] + CNTR_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CNTR; i++) begin
            if (idx == IDX_W'(i)) begin
                rd_data = DATA_W'(cnt[i]);
            end
        end
    end

endmodule

// File: rtl/udp_reg_responder.sv
// Register-ring terminating stage: answers one tagged block of counters and
// sw regs, forwards all other traffic. Ports: reg_*_in/out ring, cntr_inc, sw_regs.
module udp_reg_responder
    import udp_reg_responder_pkg::*;
#(
    parameter int UDP_REG_SRC_WIDTH = 2,
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int TAG               = 0,
    parameter int NUM_CNTR          = 4,
    parameter int NUM_SW_REGS       = 4,
    parameter int CNTR_WIDTH        = 32,
    parameter bit RESET_ON_READ     = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         reg_req_in,
    input  logic                         reg_ack_in,
    input  logic                         reg_rd_wr_L_in,
    input  logic [ADDR_W-1:0]            reg_addr_in,
    input  logic [DATA_W-1:0]            reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,
    output logic                         reg_req_out,
    output logic                         reg_ack_out,
    output logic                         reg_rd_wr_L_out,
    output logic [ADDR_W-1:0]            reg_addr_out,
    output logic [DATA_W-1:0]            reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,
    input  logic [NUM_CNTR-1:0]          cntr_inc,
    output logic [NUM_SW_REGS*32-1:0]    sw_regs
);

    localparam int TAG_W = ADDR_W - REG_ADDR_WIDTH;
    localparam int IW    = REG_ADDR_WIDTH + 1;
    localparam logic [IW-1:0] SW_LO = IW'(NUM_CNTR);
    localparam logic [IW-1:0] SW_HI = IW'(NUM_CNTR + NUM_SW_REGS);

    logic [REG_ADDR_WIDTH-1:0] idx;
    logic [IW-1:0]             idx_x;
    logic                      hit;
    logic                      rd;
    logic                      wr;
    sel_e                      sel;
    logic [DATA_W-1:0]         cntr_rd;
    logic [31:0]               sw_rd;
    logic [DATA_W-1:0]         data_nxt;
    logic [31:0]               sw_q [NUM_SW_REGS];

    assign idx   = reg_addr_in[REG_ADDR_WIDTH-1:0];
    assign idx_x = {1'b0, idx};
    // Already-acked traffic is never touched, even on a tag match.
    assign hit = reg_req_in & ~reg_ack_in &
                 (reg_addr_in[ADDR_W-1:REG_ADDR_WIDTH] == TAG_W'(TAG));
    assign rd  = hit & reg_rd_wr_L_in;
    assign wr  = hit & ~reg_rd_wr_L_in;

    always_comb begin
        sel = SEL_NONE;
        if (idx_x < SW_LO) begin
            sel = SEL_CNTR;
        end else if (idx_x < SW_HI) begin
            sel = SEL_SW;
        end
    end

    udp_reg_cntr_bank #(
        .NUM_CNTR   (NUM_CNTR),
        .CNTR_WIDTH (CNTR_WIDTH),
        .IDX_W      (REG_ADDR_WIDTH)
    ) u_cntr (
        .clk     (clk),
        .reset   (reset),
        .inc     (cntr_inc),
        .idx     (idx),
        .wr_en   (wr && sel == SEL_CNTR),
        .clr_en  (rd && sel == SEL_CNTR && RESET_ON_READ),
        .wr_data (reg_data_in[CNTR_WIDTH-1:0]),
        .rd_data (cntr_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_SW_REGS; k++) begin
                sw_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_SW_REGS; k++) begin
                if (wr && sel == SEL_SW && idx_x == SW_LO + IW'(k)) begin
                    sw_q[k] <= reg_data_in[31:0];
                end
            end
        end
    end

    always_comb begin
        sw_rd = '0;
        for (int k = 0; k < NUM_SW_REGS; k++) begin
            if (idx_x == SW_LO + IW'(k)) begin
                sw_rd = sw_q[k];
            end
        end
    end

    always_comb begin
        data_nxt = reg_data_in;
        if (rd) begin
            unique case (1'b1)
                (sel == SEL_CNTR): data_nxt = cntr_rd;
                (sel == SEL_SW):   data_nxt = DATA_W'(sw_rd);
                default:           data_nxt = DEAD_BEEF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_req_out     <= 1'b0;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= 1'b0;
            reg_addr_out    <= '0;
            reg_data_out    <= '0;
            reg_src_out     <= '0;
        end else begin
            reg_req_out     <= reg_req_in;
            reg_ack_out     <= reg_ack_in | hit;
            reg_rd_wr_L_out <= reg_rd_wr_L_in;
            reg_addr_out    <= reg_addr_in;
            reg_data_out    <= data_nxt;
            reg_src_out     <= reg_src_in;
        end
    end

    for (genvar k = 0; k < NUM_SW_REGS; k++) begin : g_sw
        assign sw_regs[32*k +: 32] = sw_q[k];
    end

endmodule

// File: tb/tb_udp_reg_responder.sv
// Bench for udp_reg_responder: two instances (32-bit plain, 8-bit clear-on-read)
// on one ring input, checked each cycle against a transaction-level model.
module tb_udp_reg_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        ack = 1'b0;
    logic        rw = 1'b0;
    logic [22:0] addr = '0;
    logic [31:0] data = '0;
    logic [1:0]  src = '0;
    logic [3:0]  inc = '0;

    logic         o_req [2];
    logic         o_ack [2];
    logic         o_rw [2];
    logic [22:0]  o_addr [2];
    logic [31:0]  o_data [2];
    logic [1:0]   o_src [2];
    logic [127:0] o_sw [2];

    always #5 clk = ~clk;

    udp_reg_responder #(.TAG(0)) d0 (
        .clk(clk), .reset(rst),
        .reg_req_in(req), .reg_ack_in(ack), .reg_rd_wr_L_in(rw),
        .reg_addr_in(addr), .reg_data_in(data), .reg_src_in(src),
        .reg_req_out(o_req[0]), .reg_ack_out(o_ack[0]),
        .reg_rd_wr_L_out(o_rw[0]), .reg_addr_out(o_addr[0]),
        .reg_data_out(o_data[0]), .reg_src_out(o_src[0]),
        .cntr_inc(inc), .sw_regs(o_sw[0])
    );

    udp_reg_responder #(.TAG(5), .CNTR_WIDTH(8), .RESET_ON_READ(1'b1)) d1 (
        .clk(clk), .reset(rst),
        .reg_req_in(req), .reg_ack_in(ack), .reg_rd_wr_L_in(rw),
        .reg_addr_in(addr), .reg_data_in(data), .reg_src_in(src),
        .reg_req_out(o_req[1]), .reg_ack_out(o_ack[1]),
        .reg_rd_wr_L_out(o_rw[1]), .reg_addr_out(o_addr[1]),
        .reg_data_out(o_data[1]), .reg_src_out(o_src[1]),
        .cntr_inc(inc), .sw_regs(o_sw[1])
    );

    typedef struct packed {
        logic        req;
        logic        ack;
        logic        rw;
        logic [22:0] addr;
        logic [31:0] data;
        logic [1:0]  src;
    } ring_t;

    ring_t       e_out [2];
    logic [31:0] m_cnt [2][4];
    logic [31:0] m_sw [2][4];
    int          n_vec = 0;
    int          n_fail = 0;

    function automatic logic [31:0] cmask(int d);
        return (d == 1) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    function automatic int tag_of(int d);
        return (d == 1) ? 5 : 0;
    endfunction

    function automatic logic [22:0] A(int t, int i);
        return 23'((t << 5) | (i & 31));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            e_out[d] = '0;
            for (int i = 0; i < 4; i++) begin
                m_cnt[d][i] = '0;
                m_sw[d][i] = '0;
            end
        end
    endtask

    // One ring transaction seen by instance d: outputs are the inputs one
    // cycle later, except that a hit gains an ack and (on reads) the word.
    task automatic model_step(int d);
        logic [31:0] nc [4];
        int idx;
        bit hit;
        idx = int'(addr[4:0]);
        hit = req && !ack && (int'(addr[22:5]) == tag_of(d));
        e_out[d].req  = req;
        e_out[d].ack  = ack | hit;
        e_out[d].rw   = rw;
        e_out[d].addr = addr;
        e_out[d].data = data;
        e_out[d].src  = src;
        for (int i = 0; i < 4; i++) begin
            nc[i] = (m_cnt[d][i] + 32'(inc[i])) & cmask(d);
        end
        if (hit && rw) begin
            if (idx < 4) begin
                e_out[d].data = m_cnt[d][idx];
                if (d == 1) nc[idx] = inc[idx] ? 32'd1 : 32'd0;
            end else if (idx < 8) begin
                e_out[d].data = m_sw[d][idx-4];
            end else begin
                e_out[d].data = 32'hDEAD_BEEF;
            end
        end else if (hit) begin
            if (idx < 4) nc[idx] = data & cmask(d);
            else if (idx < 8) m_sw[d][idx-4] = data;
        end
        for (int i = 0; i < 4; i++) begin
            m_cnt[d][i] = nc[i];
        end
    endtask

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_req", d), 128'(o_req[d]), 128'(e_out[d].req));
            chk($sformatf("d%0d_ack", d), 128'(o_ack[d]), 128'(e_out[d].ack));
            chk($sformatf("d%0d_rw", d), 128'(o_rw[d]), 128'(e_out[d].rw));
            chk($sformatf("d%0d_addr", d), 128'(o_addr[d]), 128'(e_out[d].addr));
            chk($sformatf("d%0d_data", d), 128'(o_data[d]), 128'(e_out[d].data));
            chk($sformatf("d%0d_src", d), 128'(o_src[d]), 128'(e_out[d].src));
            chk($sformatf("d%0d_sw", d), o_sw[d],
                {m_sw[d][3], m_sw[d][2], m_sw[d][1], m_sw[d][0]});
        end
    endtask

    task automatic drive(bit rq, bit ak, bit rdw, logic [22:0] a,
                         logic [31:0] dt, logic [1:0] s, logic [3:0] ic);
        req = rq; ack = ak; rw = rdw; addr = a;
        data = dt; src = s; inc = ic;
        if (rst) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic wr(int t, int i, logic [31:0] dt, logic [3:0] ic);
        drive(1'b1, 1'b0, 1'b0, A(t, i), dt, 2'd1, ic);
    endtask

    task automatic rd(int t, int i, logic [3:0] ic);
        drive(1'b1, 1'b0, 1'b1, A(t, i), $urandom, 2'd2, ic);
    endtask

    task automatic idle(logic [3:0] ic);
        drive(1'b0, 1'b0, 1'b0, 23'd0, 32'd0, 2'd0, ic);
    endtask

    initial begin
        #1 rst = 1'b1;
        model_reset();
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, A(0, 4), 32'hCAFE_F00D, 2'd3, 4'hF);
        idle(4'h0);
        chk("rst_ack", 128'(o_ack[0]), 128'd0);
        chk("rst_sw", o_sw[0], 128'd0);
        chk("rst_data_d1", 128'(o_data[1]), 128'd0);
        rst = 1'b0;

        wr(0, 4, 32'h1234_5678, 4'h0);
        chk("wr_sw0_ack", 128'(o_ack[0]), 128'd1);
        chk("wr_sw0_data", 128'(o_data[0]), 128'h1234_5678);
        chk("wr_sw0_reg", 128'(o_sw[0][31:0]), 128'h1234_5678);
        chk("wr_sw0_d1_miss", 128'(o_ack[1]), 128'd0);
        chk("model_sw0", 128'(m_sw[0][0]), 128'h1234_5678);
        rd(0, 4, 4'h0);
        chk("rd_sw0", 128'(o_data[0]), 128'h1234_5678);

        repeat (7) idle(4'b0100);
        rd(0, 2, 4'h0);
        chk("rd_cntr2", 128'(o_data[0]), 128'd7);
        rd(5, 2, 4'b0100);
        chk("ror_rd_old", 128'(o_data[1]), 128'd7);
        rd(5, 2, 4'h0);
        chk("ror_rd_one", 128'(o_data[1]), 128'd1);
        rd(0, 2, 4'h0);
        chk("plain_rd_keep", 128'(o_data[0]), 128'd8);

        drive(1'b1, 1'b0, 1'b0, A(9, 4), 32'hFFFF_0000, 2'd3, 4'h0);
        chk("miss_ack", 128'(o_ack[0]), 128'd0);
        chk("miss_req", 128'(o_req[0]), 128'd1);
        chk("miss_data", 128'(o_data[0]), 128'hFFFF_0000);
        chk("miss_sw", 128'(o_sw[0][31:0]), 128'h1234_5678);
        drive(1'b1, 1'b1, 1'b0, A(0, 4), 32'h5555_AAAA, 2'd2, 4'h0);
        chk("acked_ack", 128'(o_ack[0]), 128'd1);
        chk("acked_data", 128'(o_data[0]), 128'h5555_AAAA);
        chk("acked_sw", 128'(o_sw[0][31:0]), 128'h1234_5678);

        rd(0, 31, 4'h0);
        chk("rd31_ack", 128'(o_ack[0]), 128'd1);
        chk("rd31_data", 128'(o_data[0]), 128'hDEAD_BEEF);
        wr(0, 31, 32'h0000_0000, 4'h0);
        chk("wr31_ack", 128'(o_ack[0]), 128'd1);
        chk("wr31_sw", o_sw[0], {96'd0, 32'h1234_5678});

        wr(5, 0, 32'h0000_00FF, 4'h0);
        idle(4'b0001);
        rd(5, 0, 4'h0);
        chk("c8_wrap", 128'(o_data[1]), 128'd0);
        wr(5, 1, 32'h0000_0042, 4'b0010);
        rd(5, 1, 4'h0);
        chk("wr_beats_inc", 128'(o_data[1]), 128'h42);

        req = 1'b1; ack = 1'b0; rw = 1'b0; addr = A(0, 5);
        data = 32'hAAAA_5555; src = 2'd1; inc = 4'hF;
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        compare_all();
        chk("midrst_ack", 128'(o_ack[0]), 128'd0);
        chk("midrst_sw", o_sw[0], 128'd0);
        #2 rst = 1'b0;
        rd(0, 2, 4'h0);
        chk("post_rst_cntr", 128'(o_data[0]), 128'd0);

        repeat (2000) begin
            int k;
            int t;
            int ix;
            k = int'($urandom_range(0, 3));
            t = (k == 1) ? 5 : (k == 3) ? int'($urandom_range(0, 262143)) : 0;
            ix = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                                              : int'($urandom_range(0, 8));
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), A(t, ix), $urandom,
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
